ac_vlc_encoder: RTL and testbench

Entropy-codes the scanned AC coefficients of one slice into ProRes run/level variable-length codewords. It sits directly downstream of the memory-to-AC scan stage, which presents coefficients in scan order with the coefficient index as the outer loop and the block as the inner loop. The encoder tracks zero runs, adapts its run and level codebooks, and emits right-aligned codewords to the slice bit packer over a valid/ready handshake.

---
 rtl/ac_vlc_encoder_pkg.sv | 46 ++++
 rtl/ac_vlc_encoder_vlc_codeword.sv | 47 ++++
 rtl/ac_vlc_encoder.sv | 234 +++++++++++++++++++++++
 tb/tb_ac_vlc_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_vlc_encoder_pkg.sv
// Shared types and codebook tables for the ProRes AC run/level VLC encoder.
package prores_ac_vlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACCEPT     = 3'd1,
        ST_EMIT_RUN   = 3'd2,
        ST_EMIT_LEVEL = 3'd3,
        ST_FINISH     = 3'd4
    } state_t;

    localparam int COEFFS_PER_BLOCK = 63;

    localparam logic [7:0] RUN_CB_INIT = 8'h04;
    localparam logic [7:0] LEV_CB_INIT = 8'h05;

    localparam logic [7:0] RUN_TO_CB [0:15] = '{
        8'h06, 8'h06, 8'h05, 8'h05, 8'h04, 8'h29, 8'h29, 8'h29,
        8'h29, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h28, 8'h4C
    };

    localparam logic [7:0] LEV_TO_CB [0:9] = '{
        8'h04, 8'h0A, 8'h05, 8'h06, 8'h04, 8'h28, 8'h28, 8'h28, 8'h28, 8'h4C
    };

    function automatic logic [7:0] run_cb_of(input logic [31:0] run);
        logic [7:0] cb;
        if (run > 32'd15) begin
            cb = RUN_TO_CB[15];
        end else begin
            cb = RUN_TO_CB[run[3:0]];
        end
        return cb;
    endfunction

    function automatic logic [7:0] lev_cb_of(input logic [31:0] mag);
        logic [7:0] cb;
        if (mag > 32'd9) begin
            cb = LEV_TO_CB[9];
        end else begin
            cb = LEV_TO_CB[mag[3:0]];
        end
        return cb;
    endfunction

endpackage

// File: rtl/ac_vlc_encoder_vlc_codeword.sv
// Combinational adaptive Rice / exp-Golomb codeword builder: (codebook, value) -> right-aligned code and length.
module vlc_codeword
    import prores_ac_vlc_pkg::*;
#(
    parameter int VALUE_W = 16,
    parameter int CODE_W  = 48
) (
    input  logic [7:0]         i_cb,
    input  logic [VALUE_W-1:0] i_value,
    output logic [CODE_W-1:0]  o_code,
    output logic [5:0]         o_len
);

    localparam int VP_W = VALUE_W + 2;

    logic [2:0]      w_rice;
    logic [2:0]      w_exp;
    logic [2:0]      w_sw;
    logic [VP_W-1:0] w_value;
    logic [VP_W-1:0] w_sv;
    logic [VP_W-1:0] w_vp;
    logic [VP_W-1:0] w_rice_mask;
    logic [4:0]      w_e;

    // Split the codebook, then pick Rice or escape form; escape leading zeros are implicit in right alignment.
    always_comb begin
        w_rice      = i_cb[7:5];
        w_exp       = i_cb[4:2];
        w_sw        = {1'b0, i_cb[1:0]} + 3'd1;
        w_value     = {2'b00, i_value};
        w_sv        = VP_W'(w_sw) << w_rice;
        w_rice_mask = (VP_W'(1) << w_rice) - VP_W'(1);
        w_vp        = w_value - w_sv + (VP_W'(1) << w_exp);
        w_e         = 5'd0;
        for (int i = 0; i < VP_W; i++) begin
            w_e = w_vp[i] ? 5'(i) : w_e;
        end
        if (w_value < w_sv) begin
            o_code = CODE_W'((VP_W'(1) << w_rice) | (w_value & w_rice_mask));
            o_len  = 6'(w_value >> w_rice) + 6'd1 + {3'd0, w_rice};
        end else begin
            o_code = CODE_W'(w_vp);
            o_len  = {w_e, 1'b0} - {3'd0, w_exp} + {3'd0, w_sw} + 6'd1;
        end
    end

endmodule

// File: rtl/ac_vlc_encoder.sv
// ProRes AC run/level entropy encoder for one slice, valid/ready on both sides.
// Optional AC_VLC_STATS_EN adds a bit_total counter of emitted codeword bits.
module ac_vlc_encoder
    import prores_ac_vlc_pkg::*;
#(
    parameter int COEFF_W = 16,
    parameter int CODE_W  = 48
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        block_num,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    output logic [5:0]         out_len,
    output logic               busy,
    output logic               done
`ifdef AC_VLC_STATS_EN
    ,
    output logic [31:0]        bit_total
`endif
);

    state_t               r_state;
    state_t               w_next_state;
    logic [11:0]          r_total;
    logic [11:0]          r_consumed;
    logic [11:0]          r_run;
    logic [7:0]           r_run_cb;
    logic [7:0]           r_lev_cb;
    logic [COEFF_W-2:0]   r_abs;
    logic                 r_sign;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [CODE_W-1:0]    r_out_code;
    logic [5:0]           r_out_len;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_out_hs;
    logic                 w_coeff_zero;
    logic [COEFF_W-2:0]   w_coeff_abs;
    logic [11:0]          w_consumed_inc;
    logic [7:0]           w_cw_cb;
    logic [COEFF_W-1:0]   w_cw_value;
    logic [CODE_W-1:0]    w_cw_code;
    logic [5:0]           w_cw_len;

    assign w_accept       = in_valid && r_in_ready;
    assign w_out_hs       = r_out_valid && out_ready;
    assign w_coeff_zero   = (in_coeff == '0);
    assign w_consumed_inc = r_consumed + 12'd1;

    // Magnitude of the incoming coefficient; the most negative value saturates.
    always_comb begin
        if (!in_coeff[COEFF_W-1]) begin
            w_coeff_abs = in_coeff[COEFF_W-2:0];
        end else if (in_coeff[COEFF_W-2:0] == '0) begin
            w_coeff_abs = '1;
        end else begin
            w_coeff_abs = (COEFF_W-1)'(~in_coeff + COEFF_W'(1));
        end
    end

    // In ACCEPT the shared coder prepares the run codeword; afterwards it prepares the level codeword.
    always_comb begin
        if (r_state == ST_ACCEPT) begin
            w_cw_cb    = r_run_cb;
            w_cw_value = COEFF_W'(r_run);
        end else begin
            w_cw_cb    = r_lev_cb;
            w_cw_value = {1'b0, r_abs - (COEFF_W-1)'(1)};
        end
    end

    vlc_codeword #(
        .VALUE_W (COEFF_W),
        .CODE_W  (CODE_W)
    ) u_vlc_codeword (
        .i_cb    (w_cw_cb),
        .i_value (w_cw_value),
        .o_code  (w_cw_code),
        .o_len   (w_cw_len)
    );

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_ACCEPT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (!w_accept) begin
                    w_next_state = ST_ACCEPT;
                end else if (!w_coeff_zero) begin
                    w_next_state = ST_EMIT_RUN;
                end else if (w_consumed_inc == r_total) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_state = ST_ACCEPT;
                end
            end
            ST_EMIT_RUN: begin
                if (w_out_hs) begin
                    w_next_state = ST_EMIT_LEVEL;
                end else begin
                    w_next_state = ST_EMIT_RUN;
                end
            end
            ST_EMIT_LEVEL: begin
                if (!w_out_hs) begin
                    w_next_state = ST_EMIT_LEVEL;
                end else if (r_consumed == r_total) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_state = ST_ACCEPT;
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register plus registered status outputs derived from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == ST_ACCEPT);
            r_busy     <= (w_next_state != ST_IDLE);
            r_done     <= (w_next_state == ST_FINISH);
        end
    end

    // Slice datapath: counters, adaptive codebooks and the output codeword register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_total     <= 12'd0;
            r_consumed  <= 12'd0;
            r_run       <= 12'd0;
            r_run_cb    <= 8'd0;
            r_lev_cb    <= 8'd0;
            r_abs       <= '0;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_len   <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_total    <= 12'(block_num * 32'(COEFFS_PER_BLOCK));
                        r_consumed <= 12'd0;
                        r_run      <= 12'd0;
                        r_run_cb   <= RUN_CB_INIT;
                        r_lev_cb   <= LEV_CB_INIT;
                    end
                end
                ST_ACCEPT: begin
                    if (w_accept) begin
                        r_consumed <= w_consumed_inc;
                        if (w_coeff_zero) begin
                            r_run <= r_run + 12'd1;
                        end else begin
                            r_abs       <= w_coeff_abs;
                            r_sign      <= in_coeff[COEFF_W-1];
                            r_out_code  <= w_cw_code;
                            r_out_len   <= w_cw_len;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_EMIT_RUN: begin
                    if (w_out_hs) begin
                        r_out_code <= {w_cw_code[CODE_W-2:0], r_sign};
                        r_out_len  <= w_cw_len + 6'd1;
                    end
                end
                ST_EMIT_LEVEL: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_run_cb    <= run_cb_of(32'(r_run));
                        r_lev_cb    <= lev_cb_of(32'(r_abs));
                        r_run       <= 12'd0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AC_VLC_STATS_EN
    logic [31:0] r_bit_total;

    // Running total of emitted bits for the current slice.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_total <= 32'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_bit_total <= 32'd0;
        end else if (w_out_hs) begin
            r_bit_total <= r_bit_total + 32'(r_out_len);
        end else begin
            r_bit_total <= r_bit_total;
        end
    end

    assign bit_total = r_bit_total;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign out_len   = r_out_len;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ac_vlc_encoder.sv
// Scoreboard bench for ac_vlc_encoder: a reference model queues expected codewords, a monitor checks them.
module tb_ac_vlc_encoder;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        block_num = 32'd0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_coeff = 16'sd0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [47:0]        out_code;
    logic [5:0]         out_len;
    logic               busy;
    logic               done;
`ifdef AC_VLC_STATS_EN
    logic [31:0]        bit_total;
`endif

    ac_vlc_encoder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .block_num (block_num),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_len   (out_len),
        .busy      (busy),
        .done      (done)
`ifdef AC_VLC_STATS_EN
        ,
        .bit_total (bit_total)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        longint code;
        int     len;
    } exp_t;

    exp_t   sb[$];
    int     coeffs[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     acc_cnt = 0;
    int     exp_total = 0;
    int     last_event = -10;
    int     done_cnt = 0;
    longint bit_sum = 0;
    logic   hold = 1'b0;
    logic   prev_stall = 1'b0;
    logic [47:0] prev_code = 48'd0;
    logic [5:0]  prev_len = 6'd0;

    int run_tab[16] = '{6, 6, 5, 5, 4, 'h29, 'h29, 'h29, 'h29, 'h28, 'h28, 'h28, 'h28, 'h28, 'h28, 'h4C};
    int lev_tab[10] = '{4, 'hA, 5, 6, 4, 'h28, 'h28, 'h28, 'h28, 'h4C};

    // Reference codeword straight from the codebook arithmetic.
    function automatic exp_t ref_cw(input int cb, input int v);
        exp_t r;
        int rice, ex, sw, sv, vp, e;
        rice = cb / 32;
        ex   = (cb / 4) % 8;
        sw   = (cb % 4) + 1;
        sv   = sw * (1 << rice);
        if (v < sv) begin
            r.len  = v / (1 << rice) + 1 + rice;
            r.code = longint'((1 << rice) + (v % (1 << rice)));
        end else begin
            vp = v - sv + (1 << ex);
            e  = 0;
            while ((vp >> (e + 1)) != 0) e++;
            r.len  = (e - ex + sw) + (e + 1);
            r.code = longint'(vp);
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clock);
        #1;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: scoreboard pops, stall stability, done timing.
    initial forever begin
        @(negedge clock);
        cyc++;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_code != prev_code || out_len != prev_len) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b code=%h len=%0d exp v=1 code=%h len=%0d",
                             out_valid, out_code, out_len, prev_code, prev_len);
                end
            end
            if (out_valid) begin
                checks++;
                if (in_ready) begin
                    errors++;
                    $display("FAIL ready_while_emit got in_ready=1 exp 0");
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (acc_cnt == exp_total && in_coeff == 16'sd0) last_event = cyc;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_code got code=%h len=%0d exp none", out_code, out_len);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_code != 48'(e.code) || out_len != 6'(e.len)) begin
                        errors++;
                        $display("FAIL codeword got code=%h len=%0d exp code=%h len=%0d",
                                 out_code, out_len, 48'(e.code), e.len);
                    end
                    if (sb.size() == 0 && acc_cnt == exp_total) last_event = cyc;
                end
                bit_sum += longint'(out_len);
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (cyc != last_event + 1) begin
                    errors++;
                    $display("FAIL done_timing got cycle %0d exp %0d", cyc, last_event + 1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_code  = out_code;
            prev_len   = out_len;
        end
    end

    task automatic gen_random(input int n);
        int r, m;
        coeffs.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      m = 0;
            else if (r < 90) m = $urandom_range(1, 4);
            else if (r < 97) m = $urandom_range(1, 300);
            else if (r < 99) m = $urandom_range(1, 32767);
            else             m = -32768;
            if (m != -32768 && $urandom_range(0, 1) == 1) m = -m;
            coeffs.push_back(m);
        end
    endtask

    // Drive one slice from coeffs; abort_at >= 0 stops after that many accepts.
    task automatic run_slice(input int nblk, input int abort_at);
        int run, run_cb, lev_cb, a, t, d0;
        exp_t e;
        run = 0; run_cb = 4; lev_cb = 5;
        acc_cnt = 0; exp_total = nblk * 63; last_event = -10; bit_sum = 0;
        d0 = done_cnt;
        @(posedge clock); #1;
        block_num = 32'(nblk); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < coeffs.size(); i++) begin
            if (i == abort_at) break;
            if (coeffs[i] == 0) begin
                run++;
            end else begin
                a = (coeffs[i] < 0) ? -coeffs[i] : coeffs[i];
                if (a > 32767) a = 32767;
                sb.push_back(ref_cw(run_cb, run));
                e = ref_cw(lev_cb, a - 1);
                e.code = e.code * 2 + ((coeffs[i] < 0) ? 1 : 0);
                e.len  = e.len + 1;
                sb.push_back(e);
                run_cb = run_tab[(run > 15) ? 15 : run];
                lev_cb = lev_tab[(a > 9) ? 9 : a];
                run = 0;
            end
            in_valid = 1'b1;
            in_coeff = 16'(coeffs[i]);
            if (i == 10) begin
                start = 1'b1;
                block_num = 32'd1;
            end
            t = 0;
            @(negedge clock);
            while (!in_ready && t < 2000) begin
                @(negedge clock);
                t++;
            end
            if (t >= 2000) begin
                $display("FAIL accept_timeout got no in_ready exp in_ready within 2000 cycles");
                $fatal(1, "stalled");
            end
            @(posedge clock); #1;
            in_valid = 1'b0;
            start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end
        if (abort_at >= 0) return;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL done_count got %0d exp %0d", done_cnt - d0, 1);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL undrained got %0d pending exp 0", sb.size());
            sb.delete();
        end
`ifdef AC_VLC_STATS_EN
        checks++;
        if (longint'(bit_total) != bit_sum) begin
            errors++;
            $display("FAIL bit_total got %0d exp %0d", bit_total, bit_sum);
        end
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({in_ready, out_valid, busy, done} != 4'b0000 || out_code != 48'd0 || out_len != 6'd0) begin
            errors++;
            $display("FAIL %s got rdy=%0b v=%0b code=%h len=%0d busy=%0b done=%0b exp all 0",
                     name, in_ready, out_valid, out_code, out_len, busy, done);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset_state");
        @(posedge clock); #1;
        reset_n = 1'b1;

        coeffs.delete();
        for (int i = 0; i < 63; i++) coeffs.push_back(0);
        run_slice(1, -1);

        coeffs[0] = 1;
        run_slice(1, -1);

        for (int i = 0; i < 63; i++) coeffs[i] = 0;
        coeffs[5] = -3;
        coeffs[6] = 1;
        hold = 1'b1;
        fork
            begin
                t = 0;
                while (!out_valid && t < 500) begin
                    @(negedge clock);
                    t++;
                end
                repeat (5) @(negedge clock);
                checks++;
                if (!out_valid || in_ready) begin
                    errors++;
                    $display("FAIL stall_5 got v=%0b rdy=%0b exp v=1 rdy=0", out_valid, in_ready);
                end
                hold = 1'b0;
            end
        join_none
        run_slice(1, -1);

        for (int s = 0; s < 6; s++) begin
            int nb;
            nb = $urandom_range(1, 6);
            gen_random(nb * 63);
            if (s == 2) coeffs[nb * 63 - 1] = 7;
            if (s == 3) coeffs[nb * 63 - 1] = -32768;
            run_slice(nb, -1);
        end

        gen_random(32 * 63);
        run_slice(32, -1);

        gen_random(32 * 63);
        run_slice(32, 100);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #2;
        check_reset_outputs("reset_mid_slice");
        sb.delete();
        exp_total = 0;
        last_event = -10;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("post_reset_idle");

        gen_random(2 * 63);
        run_slice(2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
